// File: rtl/ps2_mouse_bcd_scheduler.sv
//------------------------------------------------------------------------------
// ps2_mouse_bcd_scheduler
//   Once per video frame, converts the mouse Z accumulator and the left,
//   middle and right click counters to BCD for the VGA text path. A single
//   iterative double-dabble converter is time-shared in fixed order
//   Z, L, M, R. The four results are staged and then committed to the output
//   registers on a single edge, so the display never shows a mix of old and
//   new values.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     frame_tick        one-cycle refresh request (vsync start)
//     z_axis_bin        unsigned Z accumulator        [Z_BITS]
//     left/middle/right_cnt  click counters           [CNT_BITS]
//     ariphmetic_bcd    Z as 5 BCD digits             [20]
//     left/middle/right_bcd  {hund[1:0],tens,units}   [10]
//     busy              refresh in progress
//     update_done       one-cycle pulse, high in the first cycle new
//                       outputs are visible
//     overrun           one-cycle pulse after a tick dropped while busy
//
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_bcd_scheduler #(
  parameter int Z_BITS   = 16,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [Z_BITS-1:0]   z_axis_bin,
  input  logic [CNT_BITS-1:0] left_cnt,
  input  logic [CNT_BITS-1:0] middle_cnt,
  input  logic [CNT_BITS-1:0] right_cnt,
  output logic [19:0]         ariphmetic_bcd,
  output logic [9:0]          left_bcd,
  output logic [9:0]          middle_bcd,
  output logic [9:0]          right_bcd,
  output logic                busy,
  output logic                update_done,
  output logic                overrun
);

  // Shift register is wide enough for whichever operand is larger.
  localparam int SH_W = (Z_BITS > CNT_BITS) ? Z_BITS : CNT_BITS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CONV   = 3'd2,
    S_STORE  = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_Z = 2'd0,
    SEL_L = 2'd1,
    SEL_M = 2'd2,
    SEL_R = 2'd3
  } sel_t;

  state_t state, state_nxt;
  sel_t   sel;

  // Snapshots taken when a refresh starts
  logic [Z_BITS-1:0]   z_snap;
  logic [CNT_BITS-1:0] l_snap, m_snap, r_snap;

  // Staging registers, copied to the outputs together at commit
  logic [19:0] z_stage;
  logic [9:0]  l_stage, m_stage, r_stage;

  // Double-dabble datapath
  logic [SH_W-1:0] shreg;
  logic [19:0]     bcd;
  logic [19:0]     bcd_adj;
  logic [4:0]      iter;
  logic [SH_W-1:0] load_val;

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_tick) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_CONV;
      S_CONV:   if (iter == 5'd1) state_nxt = S_STORE;
      S_STORE:  state_nxt = (sel == SEL_R) ? S_COMMIT : S_LOAD;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  //--------------------------------------------------------------------------
  // Operand for the current requester, left-aligned in the shift register so
  // that its MSB is the first bit shifted into the BCD accumulator.
  //--------------------------------------------------------------------------
  always_comb begin
    load_val = '0;
    case (sel)
      SEL_Z:   load_val = SH_W'(z_axis_snap_ext()) ;
      SEL_L:   load_val = SH_W'(l_snap) << (SH_W - CNT_BITS);
      SEL_M:   load_val = SH_W'(m_snap) << (SH_W - CNT_BITS);
      default: load_val = SH_W'(r_snap) << (SH_W - CNT_BITS);
    endcase
  end

  function automatic logic [SH_W-1:0] z_axis_snap_ext();
    return SH_W'(z_snap) << (SH_W - Z_BITS);
  endfunction

  // Add-3 correction on every nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  //--------------------------------------------------------------------------
  // Datapath and output registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel            <= SEL_Z;
      z_snap         <= '0;
      l_snap         <= '0;
      m_snap         <= '0;
      r_snap         <= '0;
      z_stage        <= '0;
      l_stage        <= '0;
      m_stage        <= '0;
      r_stage        <= '0;
      shreg          <= '0;
      bcd            <= '0;
      iter           <= '0;
      ariphmetic_bcd <= '0;
      left_bcd       <= '0;
      middle_bcd     <= '0;
      right_bcd      <= '0;
      update_done    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      update_done <= 1'b0;
      // Any tick outside IDLE (including the COMMIT cycle) is dropped
      overrun     <= frame_tick && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            z_snap <= z_axis_bin;
            l_snap <= left_cnt;
            m_snap <= middle_cnt;
            r_snap <= right_cnt;
            sel    <= SEL_Z;
          end
        end

        S_LOAD: begin
          shreg <= load_val;
          bcd   <= '0;
          iter  <= (sel == SEL_Z) ? 5'(Z_BITS) : 5'(CNT_BITS);
        end

        S_CONV: begin
          bcd   <= {bcd_adj[18:0], shreg[SH_W-1]};
          shreg <= shreg << 1;
          iter  <= iter - 5'd1;
        end

        S_STORE: begin
          case (sel)
            SEL_Z: begin z_stage <= bcd;       sel <= SEL_L; end
            SEL_L: begin l_stage <= bcd[9:0];  sel <= SEL_M; end
            SEL_M: begin m_stage <= bcd[9:0];  sel <= SEL_R; end
            default: r_stage <= bcd[9:0];
          endcase
        end

        S_COMMIT: begin
          ariphmetic_bcd <= z_stage;
          left_bcd       <= l_stage;
          middle_bcd     <= m_stage;
          right_bcd      <= r_stage;
          update_done    <= 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_bcd_scheduler.sv
`default_nettype none

module tb_ps2_mouse_bcd_scheduler;

  localparam int Z_BITS   = 16;
  localparam int CNT_BITS = 8;
  localparam int LATENCY  = Z_BITS + 3 * CNT_BITS + 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                frame_tick;
  logic [Z_BITS-1:0]   z_axis_bin;
  logic [CNT_BITS-1:0] left_cnt, middle_cnt, right_cnt;
  logic [19:0]         ariphmetic_bcd;
  logic [9:0]          left_bcd, middle_bcd, right_bcd;
  logic                busy, update_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last committed values
  logic [19:0] exp_z;
  logic [9:0]  exp_l, exp_m, exp_r;

  always #5 clk = ~clk;

  ps2_mouse_bcd_scheduler #(.Z_BITS(Z_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .z_axis_bin     (z_axis_bin),
    .left_cnt       (left_cnt),
    .middle_cnt     (middle_cnt),
    .right_cnt      (right_cnt),
    .ariphmetic_bcd (ariphmetic_bcd),
    .left_bcd       (left_bcd),
    .middle_bcd     (middle_bcd),
    .right_bcd      (right_bcd),
    .busy           (busy),
    .update_done    (update_done),
    .overrun        (overrun)
  );

  // Decimal digits by plain arithmetic
  function automatic logic [19:0] to_bcd20(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] to_bcd10(input int v);
    return {2'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One refresh. hold: cycles frame_tick stays high at start (>=1).
  // tick2_at: negedge index (1-based after start) at which an extra tick is
  // driven; 0 means none. Inputs are scrambled during the refresh.
  task automatic run_refresh(input logic [15:0] z, input logic [7:0] l,
                             input logic [7:0] m, input logic [7:0] r,
                             input int hold, input int tick2_at,
                             input string name);
    int   busy_cycles, n_done, n_ovr, exp_ovr;
    logic held_ok, done;
    logic [19:0] nz;
    logic [9:0]  nl, nm, nr;
    nz = to_bcd20(int'(z));
    nl = to_bcd10(int'(l));
    nm = to_bcd10(int'(m));
    nr = to_bcd10(int'(r));
    exp_ovr = (hold - 1) + ((tick2_at >= hold && tick2_at <= LATENCY) ? 1 : 0);

    @(negedge clk);
    z_axis_bin = z; left_cnt = l; middle_cnt = m; right_cnt = r;
    frame_tick = 1'b1;
    n_done = 0; n_ovr = 0; held_ok = 1'b1; done = 1'b0; busy_cycles = -1;
    for (int c = 1; c <= LATENCY + 20 && !done; c++) begin
      @(negedge clk);
      frame_tick = (c < hold) || (c == tick2_at);
      z_axis_bin = Z_BITS'($urandom);
      left_cnt   = CNT_BITS'($urandom);
      middle_cnt = CNT_BITS'($urandom);
      right_cnt  = CNT_BITS'($urandom);
      if (update_done) n_done++;
      if (overrun)     n_ovr++;
      if (busy) begin
        if (ariphmetic_bcd !== exp_z || left_bcd !== exp_l ||
            middle_bcd !== exp_m || right_bcd !== exp_r) held_ok = 1'b0;
      end else begin
        done = 1'b1;
        busy_cycles = c - 1;
      end
    end
    frame_tick = 1'b0;

    n_checks++;
    if (busy_cycles !== LATENCY) begin
      n_fail++;
      $display("FAIL %s latency: busy cycles=%0d required=%0d", name, busy_cycles, LATENCY);
    end
    n_checks++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL %s hold: outputs changed while busy (required constant until commit)", name);
    end
    n_checks++;
    if (n_done !== 1 || update_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s update_done: pulses=%0d at_commit=%b required 1 pulse with new outputs", name, n_done, update_done);
    end
    n_checks++;
    if (n_ovr !== exp_ovr) begin
      n_fail++;
      $display("FAIL %s overrun: pulses=%0d required=%0d", name, n_ovr, exp_ovr);
    end
    n_checks++;
    if (ariphmetic_bcd !== nz || left_bcd !== nl || middle_bcd !== nm || right_bcd !== nr) begin
      n_fail++;
      $display("FAIL %s values: z=%h l=%h m=%h r=%h required z=%h l=%h m=%h r=%h",
               name, ariphmetic_bcd, left_bcd, middle_bcd, right_bcd, nz, nl, nm, nr);
    end
    exp_z = nz; exp_l = nl; exp_m = nm; exp_r = nr;

    @(negedge clk);
    n_checks++;
    if (update_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after: update_done=%b busy=%b overrun=%b required 0 0 0", name, update_done, busy, overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0;
    z_axis_bin = '0; left_cnt = '0; middle_cnt = '0; right_cnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_z = '0; exp_l = '0; exp_m = '0; exp_r = '0;
    n_checks++;
    if (ariphmetic_bcd !== 20'h0 || left_bcd !== 10'h0 || middle_bcd !== 10'h0 ||
        right_bcd !== 10'h0 || busy !== 1'b0 || update_done !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: z=%h l=%h m=%h r=%h busy=%b done=%b ovr=%b required all 0",
               ariphmetic_bcd, left_bcd, middle_bcd, right_bcd, busy, update_done, overrun);
    end
  endtask

  task automatic test_zero();
    run_refresh(16'd0, 8'd0, 8'd0, 8'd0, 1, 0, "zero");
  endtask

  task automatic test_max();
    run_refresh(16'd65535, 8'd255, 8'd0, 8'd100, 1, 0, "max");
  endtask

  task automatic test_snapshot();
    run_refresh(16'd1234, 8'd7, 8'd42, 8'd199, 1, 0, "snap1234");
    run_refresh(16'd9999, 8'd1, 8'd2, 8'd3, 1, 0, "snap9999");
  endtask

  task automatic test_overrun();
    run_refresh(16'd321, 8'd11, 8'd22, 8'd33, 1, 10, "ovr_mid");
    run_refresh(16'd54321, 8'd99, 8'd100, 8'd101, 1, LATENCY, "ovr_commit");
    run_refresh(16'd4096, 8'd128, 8'd64, 8'd32, 3, 0, "ovr_hold");
  endtask

  task automatic test_reset_mid();
    int   n_done;
    @(negedge clk);
    z_axis_bin = 16'd777; left_cnt = 8'd5; middle_cnt = 8'd6; right_cnt = 8'd7;
    frame_tick = 1'b1;
    n_done = 0;
    // Negedge 34 lies inside the middle-counter conversion
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (update_done) n_done++;
    end
    rst = 1'b1;
    #1;
    exp_z = '0; exp_l = '0; exp_m = '0; exp_r = '0;
    n_checks++;
    if (ariphmetic_bcd !== 20'h0 || left_bcd !== 10'h0 || middle_bcd !== 10'h0 ||
        right_bcd !== 10'h0 || busy !== 1'b0 || update_done !== 1'b0 || n_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: z=%h l=%h m=%h r=%h busy=%b done_pulses=%0d required all 0",
               ariphmetic_bcd, left_bcd, middle_bcd, right_bcd, busy, n_done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid idle: busy=%b update_done=%b required 0 0", busy, update_done);
    end
    run_refresh(16'd2024, 8'd12, 8'd34, 8'd56, 1, 0, "after_reset");
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 256; i++)
      run_refresh(16'($urandom), 8'(i), 8'($urandom), 8'($urandom), 1, 0, "sweep_left");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_refresh(16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  int'($urandom_range(1, 3)), int'($urandom_range(0, LATENCY)), "random");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_snapshot();
    test_overrun();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
